// File: rtl/erasure_location_seq.sv
// rtl/erasure_location_seq.sv - sequential erasure locator scanning a DUE flag vector MSB first
module erasure_location_seq #(
  parameter  int NUM_SYMBOLS  = 10,
  parameter  int MAX_ERASURES = 2,
  localparam int LOC_W        = $clog2(NUM_SYMBOLS),
  localparam int CNT_W        = $clog2(MAX_ERASURES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_SYMBOLS-1:0]        due_info_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_ERASURES*LOC_W-1:0] loc_out,
  output logic [CNT_W-1:0]              erasure_cnt_out,
  output logic                          overflow_out
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state, next_state;
  logic [NUM_SYMBOLS-1:0]   sr, sr_shifted;
  logic [LOC_W-1:0]         idx;
  logic [CNT_W-1:0]         cnt;
  logic                     overflow;
  logic [LOC_W-1:0]         slot [MAX_ERASURES];
  logic                     accept, flag, cnt_full;

  assign accept     = in_valid && in_ready && (state == IDLE);
  assign sr_shifted = sr << 1;
  assign flag       = sr[NUM_SYMBOLS-1];
  assign cnt_full   = (cnt == CNT_W'(MAX_ERASURES));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (due_info_in == '0) ? DONE : SCAN;
      SCAN: begin
        if (flag && cnt_full)
          next_state = DONE;
        else if (sr_shifted == '0 || idx == LOC_W'(NUM_SYMBOLS - 1))
          next_state = DONE;
      end
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready is a register so it carries no path from out_ready or rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      idx       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      for (int k = 0; k < MAX_ERASURES; k++) slot[k] <= '0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state == DONE);
      in_ready  <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            sr       <= due_info_in;
            idx      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < MAX_ERASURES; k++) slot[k] <= '0;
          end
        end
        SCAN: begin
          if (flag && cnt_full) begin
            overflow <= 1'b1;
          end else begin
            if (flag) begin
              for (int k = 0; k < MAX_ERASURES; k++)
                if (cnt == CNT_W'(k)) slot[k] <= idx;
              cnt <= cnt + 1'b1;
            end
            sr  <= sr_shifted;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    loc_out = '0;
    for (int k = 0; k < MAX_ERASURES; k++) loc_out[k*LOC_W +: LOC_W] = slot[k];
  end

  assign erasure_cnt_out = cnt;
  assign overflow_out    = overflow;

endmodule

// File: tb/tb_erasure_location_seq.sv
// tb/tb_erasure_location_seq.sv - scoreboard bench for erasure_location_seq
module tb_erasure_location_seq;

  localparam int N  = 10;
  localparam int M  = 2;
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(M + 1);
  localparam int N2  = 16;
  localparam int M2  = 4;
  localparam int LW2 = $clog2(N2);
  localparam int CW2 = $clog2(M2 + 1);

  typedef struct {
    logic [M*LW-1:0] loc;
    logic [CW-1:0]   cnt;
    logic            ovf;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, overflow_out;
  logic [N-1:0]    due;
  logic [M*LW-1:0] loc_out;
  logic [CW-1:0]   cnt_out;

  logic in_valid2, in_ready2, out_valid2, out_ready2, overflow_out2;
  logic [N2-1:0]     due2;
  logic [M2*LW2-1:0] loc_out2;
  logic [CW2-1:0]    cnt_out2;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  erasure_location_seq #(.NUM_SYMBOLS(N), .MAX_ERASURES(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .due_info_in(due), .out_valid(out_valid), .out_ready(out_ready),
    .loc_out(loc_out), .erasure_cnt_out(cnt_out), .overflow_out(overflow_out)
  );

  erasure_location_seq #(.NUM_SYMBOLS(N2), .MAX_ERASURES(M2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .due_info_in(due2), .out_valid(out_valid2), .out_ready(out_ready2),
    .loc_out(loc_out2), .erasure_cnt_out(cnt_out2), .overflow_out(overflow_out2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    int c, last;
    c = 0; last = -1;
    e.loc = '0; e.ovf = 1'b0;
    for (int l = 0; l < N; l++) begin
      if (d[N-1-l]) begin
        last = l;
        if (c < M) begin
          e.loc[c*LW +: LW] = LW'(l);
          c++;
        end else begin
          e.ovf = 1'b1;
          break;
        end
      end
    end
    e.cnt = CW'(c);
    e.lat = (last < 0) ? 1 : last + 2;
    return e;
  endfunction

  task automatic accept(input logic [N-1:0] d);
    int w;
    @(negedge clk);
    in_valid = 1'b1; due = d;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; due = N'($urandom);
  endtask

  task automatic run(input logic [N-1:0] d, input int hold);
    exp_t e;
    int n;
    logic [M*LW-1:0] l0;
    sb.push_back(model(d));
    accept(d);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("out_valid_seen", out_valid, 1'b1);
    e = sb.pop_front();
    chk("latency", n + 1, e.lat);
    chk("loc", loc_out, e.loc);
    chk("cnt", cnt_out, e.cnt);
    chk("ovf", overflow_out, e.ovf);
    l0 = loc_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_loc", loc_out, l0);
      chk("hold_cnt", cnt_out, e.cnt);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; due = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; due2 = '0; out_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_loc", loc_out, '0);
    chk("rst_cnt", cnt_out, '0);
    chk("rst_ovf", overflow_out, 1'b0);
    @(negedge clk); rst = 1'b0;

    run(10'b0000100100, 0);
    run(10'b0000000000, 0);
    run(10'b1000000001, 0);
    run(10'b0110010000, 0);
    run(10'b0000100100, 5);
    run(10'b1111111111, 0);

    accept(10'b1000000001);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_loc", loc_out, '0);
    chk("midrst_cnt", cnt_out, '0);
    chk("midrst_ovf", overflow_out, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_ready", in_ready, 1'b1);
    run(10'b0000100100, 0);

    for (int r = 0; r < 4; r++) run(N'($urandom), r);

    @(negedge clk); in_valid2 = 1'b1; due2 = 16'h8421;
    n = 0;
    while (!in_ready2 && n < 50) begin @(negedge clk); n++; end
    chk("w_accept_ready", in_ready2, 1'b1);
    @(posedge clk); #1; in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 40) begin @(posedge clk); #1; n++; end
    chk("w_out_valid", out_valid2, 1'b1);
    chk("w_latency", n + 1, 17);
    chk("w_loc", loc_out2, {4'd15, 4'd10, 4'd5, 4'd0});
    chk("w_cnt", cnt_out2, 3'd4);
    chk("w_ovf", overflow_out2, 1'b0);
    @(negedge clk); out_ready2 = 1'b1;
    @(posedge clk); #1; out_ready2 = 1'b0;
    chk("w_post_ready", in_ready2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/erasure_location_seq.md
# erasure_location_seq

Sequential, parametrised erasure locator for the rank-level RS erasure decoder. It accepts a per-symbol DUE/erasure flag vector and scans it one symbol per cycle, first symbol first. It emits up to MAX_ERASURES symbol locations, an erasure count and an overflow flag to the erasure-correction datapath over valid/ready handshakes. Scanning ends early once no flagged symbols remain, or once the erasure budget is exceeded.

## Interface
- NUM_SYMBOLS, 10: symbols per codeword; legal range is at least 2.
- MAX_ERASURES, 2: number of location slots; legal range is 1..NUM_SYMBOLS.
- LOC_W, $clog2(NUM_SYMBOLS): width of one location (derived).
- CNT_W, $clog2(MAX_ERASURES+1): width of the count (derived).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a flag vector is offered.
- in_ready  out  1  the block can accept a vector; high only in IDLE.
- due_info_in  in  NUM_SYMBOLS  flag vector; bit NUM_SYMBOLS-1-l flags location l.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- loc_out  out  MAX_ERASURES*LOC_W  location slots; slot k is at [k*LOC_W +: LOC_W] and slot 0 holds the smallest location.
- erasure_cnt_out  out  CNT_W  number of filled slots.
- overflow_out  out  1  more than MAX_ERASURES flags were present.

## Operation
- FSM has three states: IDLE, SCAN and DONE.
- Location mapping: bit index i corresponds to location NUM_SYMBOLS-1-i. The MSB is location 0.
- IDLE:
  - in_ready is 1.
  - On in_valid, the vector is captured into shift register sr, and the location counter idx is cleared to 0.
  - cnt, the slots and overflow are cleared.
  - If the captured vector is zero, next state is DONE; otherwise next state is SCAN.
- SCAN, each cycle, examines sr[NUM_SYMBOLS-1] at location idx:
  - If the bit is 1 and cnt < MAX_ERASURES: slot[cnt] <= idx and cnt <= cnt+1.
  - If the bit is 1 and cnt == MAX_ERASURES: overflow <= 1, and next state is DONE at once.
  - Otherwise: sr <= sr << 1 and idx <= idx+1.
  - Exit to DONE when the shifted sr is all-zero, or when idx == NUM_SYMBOLS-1.
- DONE:
  - out_valid is 1.
  - loc_out, erasure_cnt_out and overflow_out are held stable until out_ready is sampled high.
  - After that handshake the FSM returns to IDLE.
- Unused slots (index >= cnt) read 0. Consumers use erasure_cnt_out to tell which slots are filled.
- On overflow the slots hold the first MAX_ERASURES locations and the count saturates at MAX_ERASURES. The downstream logic treats the word as uncorrectable.
- due_info_in is ignored outside the accepting cycle.
- rst in any state:
  - The FSM goes to IDLE and any in-flight result is discarded.
  - out_valid, loc_out, erasure_cnt_out, overflow_out, sr, idx and cnt all reset to 0.
  - in_ready is 1 from the first cycle after rst deasserts.

## Timing
- Reset values: in_ready = 0 while rst is high and 1 afterwards. out_valid = 0, loc_out = 0, erasure_cnt_out = 0, overflow_out = 0.
- For an accept at cycle T:
  - Location l is examined at cycle T+1+l.
  - out_valid rises at T+2+L, where L is the last examined location: the last flagged location, or the (MAX_ERASURES+1)-th flagged location on overflow.
- An all-zero vector gives out_valid at T+1 with count 0.
- Worst-case latency is NUM_SYMBOLS+1 cycles from accept to out_valid.
- All outputs are registered. in_ready is decoded from the state register only and has no combinational path from out_ready.
- The block holds one transaction in flight.
- Throughput is at most one result per (latency + 2) cycles. There is one DONE->IDLE cycle, and no new accept happens in the cycle of the out handshake.
- Backpressure: if out_ready stays low, DONE persists indefinitely and in_ready stays 0.

## Test plan
- Reset, then N=10, M=2, due=10'b0000100100 accepted at T: out_valid at T+9, slots {4,7}, count 2, overflow 0.
- due=0: out_valid at T+1, count 0, loc_out 0, overflow 0.
- due=10'b1000000001: slots {0,9}, count 2, out_valid at T+11.
- due=10'b0110010000 with M=2: slots {1,2}, overflow 1, out_valid at T+7, count 2.
- Hold out_ready low for 5 cycles in DONE:
  - Outputs are stable and in_ready stays 0.
  - After the handshake, in_ready returns to 1 on the next cycle.
  - A second vector is then accepted and gives the correct result.
- Assert rst mid-SCAN: the next cycle shows out_valid 0 and all outputs 0; in_ready is 1 after rst deasserts, and a new vector gives the correct result. Then rerun with N=16, M=4 and due=16'h8421: slots {0,5,10,15}, count 4.
